rf_rotating: RTL and testbench

//  Parametrised CGRA register-file functional unit; next generation of the 16-entry RF.

---
 rtl/rf_rotating.sv | 83 ++++++++
 tb/tb_rf_rotating.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rf_rotating.sv
// Rotating-base register-file FU: logical addresses are offset by a base pointer so delay
// lines shift by advancing the pointer. Registered read with write bypass, combinational pass slots.
module rf_rotating #(
  parameter int D_WIDTH         = 8,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int NUM_INPUTS      = 4,
  parameter int SRC_WIDTH       = 2,
  parameter int NUM_OUTPUTS     = 2,
  parameter int I_DECODED_WIDTH = 2*SRC_WIDTH+REG_ADDR_WIDTH+5
) (
  input  logic                            iClk,
  input  logic                            iReset,
  input  logic [NUM_INPUTS*D_WIDTH-1:0]   iInputs,
  input  logic [I_DECODED_WIDTH-1:0]      iDecodedInstruction,
  output logic [NUM_OUTPUTS*D_WIDTH-1:0]  oOutputs,
  output logic [REG_ADDR_WIDTH-1:0]       oBase
);
  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  typedef struct packed {
    logic                      advance;
    logic                      rdImm;
    logic                      rdInd;
    logic                      wrImm;
    logic                      wrInd;
    logic [REG_ADDR_WIDTH-1:0] immAddr;
    logic [SRC_WIDTH-1:0]      srcB;
    logic [SRC_WIDTH-1:0]      srcA;
  } instr_t;

  instr_t                    ins;
  logic [D_WIDTH-1:0]        regs [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0] base;
  logic [D_WIDTH-1:0]        readQ;
  logic [D_WIDTH-1:0]        wrData;
  logic [REG_ADDR_WIDTH-1:0] addrVal, indP, immP, rdP;
  logic                      rdEn, rdHit;

  assign ins = instr_t'(iDecodedInstruction);

  // Selects beyond NUM_INPUTS fall through to the zero default.
  always_comb begin
    wrData  = '0;
    addrVal = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (int'(ins.srcA) == k) wrData  = iInputs[k*D_WIDTH +: D_WIDTH];
      if (int'(ins.srcB) == k) addrVal = iInputs[k*D_WIDTH +: REG_ADDR_WIDTH];
    end
  end

  // Physical addresses wrap naturally at REG_ADDR_WIDTH bits; all use the pre-advance base.
  assign indP  = addrVal + base;
  assign immP  = ins.immAddr + base;
  assign rdP   = ins.rdImm ? immP : indP;
  assign rdEn  = ins.rdImm | ins.rdInd;
  assign rdHit = (ins.wrImm && rdP == immP) || (ins.wrInd && rdP == indP);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (ins.wrInd) regs[indP] <= wrData;
      if (ins.wrImm) regs[immP] <= wrData;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)           base <= '0;
    else if (ins.advance) base <= base + 1'b1;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)     readQ <= '0;
    else if (rdEn)  readQ <= rdHit ? wrData : regs[rdP];
  end

  assign oOutputs[NUM_OUTPUTS*D_WIDTH-1 -: D_WIDTH] = readQ;
  assign oBase = base;

  for (genvar k = 0; k < NUM_OUTPUTS-1; k++) begin : gPass
    assign oOutputs[k*D_WIDTH +: D_WIDTH] = regs[base + REG_ADDR_WIDTH'(k)];
  end
endmodule

// File: tb/tb_rf_rotating.sv
// Bench for rf_rotating: vector table, hand-written corner sequences and random stimulus
// compared against a logical-view model in which advance physically rotates the array.
module tb_rf_rotating;
  localparam int DW = 8, AW = 4, NI = 4, SW = 2, NO = 2, IW = 2*SW+AW+5, NR = 16;

  logic              iClk = 1'b0;
  logic              iReset;
  logic [NI*DW-1:0]  iInputs;
  logic [IW-1:0]     instr;
  logic [NO*DW-1:0]  oOutputs;
  logic [AW-1:0]     oBase;

  rf_rotating dut (
    .iClk(iClk), .iReset(iReset), .iInputs(iInputs),
    .iDecodedInstruction(instr), .oOutputs(oOutputs), .oBase(oBase)
  );

  always #5 iClk = ~iClk;

  int nTests = 0, nFail = 0;
  logic [7:0] mLg [NR];   // indexed by logical address
  int         mBase;
  logic [7:0] mRd;

  typedef struct {
    logic [IW-1:0] ins;
    logic [31:0]   inp;
    logic [7:0]    eRd;
    logic [7:0]    ePass;
    logic [3:0]    eBase;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int sa, input int sb, input int imm,
                                       input int wi, input int wm, input int ri,
                                       input int rm, input int adv);
    logic [IW-1:0] r;
    r = '0;
    r[1:0] = sa[1:0];
    r[3:2] = sb[1:0];
    r[7:4] = imm[3:0];
    r[8]   = wi[0];
    r[9]   = wm[0];
    r[10]  = ri[0];
    r[11]  = rm[0];
    r[12]  = adv[0];
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mLg[i] = 8'h00;
    mBase = 0;
    mRd   = 8'h00;
  endtask

  task automatic modelStep(input logic [IW-1:0] ins, input logic [31:0] inp);
    logic [7:0] in [NI];
    logic [7:0] dA, dB, tmp;
    int sa, sb, indL, immL, rl;
    for (int k = 0; k < NI; k++) in[k] = inp[k*8 +: 8];
    sa   = int'(ins[1:0]);
    sb   = int'(ins[3:2]);
    dA   = (sa < NI) ? in[sa] : 8'h00;
    dB   = (sb < NI) ? in[sb] : 8'h00;
    indL = int'(dB) % NR;
    immL = int'(ins[7:4]);
    if (ins[11] || ins[10]) begin
      rl = ins[11] ? immL : indL;
      if ((ins[9] && rl == immL) || (ins[8] && rl == indL)) mRd = dA;
      else mRd = mLg[rl];
    end
    if (ins[8]) mLg[indL] = dA;
    if (ins[9]) mLg[immL] = dA;
    if (ins[12]) begin
      tmp = mLg[0];
      for (int k = 0; k < NR-1; k++) mLg[k] = mLg[k+1];
      mLg[NR-1] = tmp;
      mBase = (mBase + 1) % NR;
    end
  endtask

  task automatic step(input logic [IW-1:0] ins, input logic [31:0] inp);
    instr   = ins;
    iInputs = inp;
    @(posedge iClk);
    modelStep(ins, inp);
    @(negedge iClk);
    chk("read", 32'(oOutputs[15:8]), 32'(mRd));
    chk("pass0", 32'(oOutputs[7:0]), 32'(mLg[0]));
    chk("base", 32'(oBase), 32'(mBase));
  endtask

  task automatic doReset();
    @(negedge iClk);
    iReset = 1'b1;
    instr = '0;
    #1;
    chk("rst_out", 32'(oOutputs), 32'h0);
    chk("rst_base", 32'(oBase), 32'h0);
    @(negedge iClk);
    iReset = 1'b0;
    modelReset();
  endtask

  initial begin
    iReset  = 1'b1;
    instr   = '0;
    iInputs = '0;
    modelReset();
    tbl[0] = '{mk(0,0,3,0,1,0,0,0), 32'h0000005A, 8'h00, 8'h00, 4'd0};
    tbl[1] = '{mk(0,0,3,0,0,0,1,0), 32'h00000000, 8'h5A, 8'h00, 4'd0};
    tbl[2] = '{mk(0,1,0,1,0,1,0,0), 32'h00000733, 8'h33, 8'h00, 4'd0};
    tbl[3] = '{mk(0,0,0,0,1,0,0,0), 32'h00000044, 8'h33, 8'h44, 4'd0};
    tbl[4] = '{mk(0,0,0,0,0,0,0,1), 32'h00000000, 8'h33, 8'h00, 4'd1};
    tbl[5] = '{mk(0,0,15,0,0,0,1,0), 32'h00000000, 8'h44, 8'h00, 4'd1};

    @(negedge iClk);
    chk("init_out", 32'(oOutputs), 32'h0);
    chk("init_base", 32'(oBase), 32'h0);
    iReset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      step(tbl[v].ins, tbl[v].inp);
      chk($sformatf("vec%0d_rd", v), 32'(oOutputs[15:8]), 32'(tbl[v].eRd));
      chk($sformatf("vec%0d_pass", v), 32'(oOutputs[7:0]), 32'(tbl[v].ePass));
      chk($sformatf("vec%0d_base", v), 32'(oBase), 32'(tbl[v].eBase));
    end

    // Reset in the middle of a live sequence
    step(mk(0,0,1,0,1,0,0,0), 32'h0000009C);
    step(mk(0,0,0,0,0,0,0,1), 32'h0);
    step(mk(0,0,0,0,0,0,1,0), 32'h0);
    chk("pre_rst_rd", 32'(oOutputs[15:8]), 32'h9C);
    doReset();

    // Dual write to the same register, then sweep every register
    step(mk(0,1,2,1,1,0,0,0), 32'h00000211);
    for (int l = 0; l < NR; l++) begin
      step(mk(0,0,l,0,0,0,1,0), 32'h0);
      chk("dual_sweep", 32'(oOutputs[15:8]), (l == 2) ? 32'h11 : 32'h0);
    end

    // Rotation wraps the base through a full turn
    doReset();
    for (int l = 0; l < NR; l++) step(mk(0,0,l,0,1,0,0,0), 32'(l + 1));
    for (int a = 0; a < 17; a++) step(mk(0,0,0,0,0,0,0,1), 32'h0);
    chk("rot_base", 32'(oBase), 32'h1);
    chk("rot_pass0", 32'(oOutputs[7:0]), 32'h2);
    step(mk(0,0,15,0,0,0,1,0), 32'h0);
    chk("rot_l15", 32'(oOutputs[15:8]), 32'h1);

    // Advance and write in the same cycle use the old base
    step(mk(0,0,0,0,1,0,0,1), 32'h000000AA);
    chk("advwr_base", 32'(oBase), 32'h2);
    step(mk(0,0,15,0,0,0,1,0), 32'h0);
    chk("advwr_l15", 32'(oOutputs[15:8]), 32'hAA);

    for (int n = 0; n < 400; n++) step(IW'($urandom), $urandom);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
